dds_cfg_sequencer: RTL and testbench

Command sequencer between the HPS-driven 10-bit DDS PIO word and the fabric DDS core. It decodes toggle-strobed commands into byte writes of a shadow register set (frequency tuning word, phase offset, waveform, amplitude). On commit it transfers the shadow set to the live DDS controls, either immediately or aligned to a phase-accumulator wrap with a timeout. A 5-bit status word is returned for the LED PIO.

---
 rtl/dds_cfg_sequencer.sv | 129 ++++++++++++
 tb/tb_dds_cfg_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/dds_cfg_sequencer.sv
// dds_cfg_sequencer: toggle-strobed PIO command decoder with shadow/live DDS config and wrap-aligned commit
module dds_cfg_sequencer #(
  parameter int          SYNC_TIMEOUT = 1024,
  parameter logic [31:0] RESET_FTW    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  cmd_word,
  input  logic        acc_wrap,
  output logic [31:0] ftw,
  output logic [15:0] phase_ofs,
  output logic [1:0]  wave_sel,
  output logic [7:0]  amplitude,
  output logic        cfg_load,
  output logic        dds_clr,
  output logic [4:0]  status
);
  typedef enum logic [1:0] {IDLE, WAIT_WRAP, APPLY} state_t;
  localparam int TW = $clog2(SYNC_TIMEOUT);
  // shadow and live share one packed layout: {amplitude, wave_sel, phase_ofs, ftw}
  localparam logic [57:0] CFG_RST = {8'hFF, 2'b00, 16'h0000, RESET_FTW};
  logic [9:0]    cmd_q;
  logic          tog_q;
  logic [3:0]    ptr_q, ptr_d;
  logic [57:0]   sh_q, sh_d, live_q, live_d;
  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          clr_q, clr_d, err_q, err_d, to_q, to_d, cnt_q, cnt_d;
  logic          load_q, load_d, dclr_q, dclr_d;
  logic [4:0]    status_q, status_d;
  logic          cmd, commit;
  logic [7:0]    pl;
  assign ftw       = live_q[31:0];
  assign phase_ofs = live_q[47:32];
  assign wave_sel  = live_q[49:48];
  assign amplitude = live_q[57:50];
  assign cfg_load  = load_q;
  assign dds_clr   = dclr_q;
  assign status    = status_q;
  // decode at most one command per cycle, update shadow/flags and step the commit FSM
  always_comb begin
    cmd = cmd_q[9] != tog_q;
    pl = cmd_q[7:0];
    commit = cmd && !cmd_q[8] && ptr_q == 4'd8;
    ptr_d = ptr_q;
    sh_d = sh_q;
    live_d = live_q;
    state_d = state_q;
    timer_d = timer_q;
    clr_d = clr_q;
    err_d = err_q;
    to_d = to_q;
    cnt_d = cnt_q;
    load_d = 1'b0;
    dclr_d = 1'b0;
    if (cmd && cmd_q[8]) begin
      if (pl <= 8'd8) ptr_d = pl[3:0];
      else if (pl == 8'h0F) begin
        ptr_d = 4'd0;
        err_d = 1'b0;
        to_d = 1'b0;
      end else err_d = 1'b1;
    end
    if (cmd && !cmd_q[8] && ptr_q < 4'd8) begin
      for (int i = 0; i < 6; i++) if (ptr_q == 4'(i)) sh_d[8*i +: 8] = pl;
      if (ptr_q == 4'd6) sh_d[49:48] = pl[1:0];
      if (ptr_q == 4'd7) sh_d[57:50] = pl;
      ptr_d = ptr_q + 4'd1;
    end
    if (commit && state_q != IDLE) err_d = 1'b1;
    case (state_q)
      IDLE: if (commit) begin
        clr_d = pl[1];
        timer_d = '0;
        state_d = pl[0] ? APPLY : WAIT_WRAP;
      end
      WAIT_WRAP: begin
        if (acc_wrap) state_d = APPLY;
        else if (timer_q == TW'(SYNC_TIMEOUT - 1)) begin
          to_d = 1'b1;
          state_d = APPLY;
        end else timer_d = timer_q + 1'b1;
      end
      APPLY: begin
        live_d = sh_q;
        load_d = 1'b1;
        dclr_d = clr_q;
        cnt_d = ~cnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    status_d = {ptr_d == 4'd8, cnt_d, to_d, err_d, state_d != IDLE};
  end
  // register everything; reset seeds the toggle tracker from the live input so a held level is no command
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q <= cmd_word;
      tog_q <= cmd_word[9];
      ptr_q <= 4'd0;
      sh_q <= CFG_RST;
      live_q <= CFG_RST;
      state_q <= IDLE;
      timer_q <= '0;
      clr_q <= 1'b0;
      err_q <= 1'b0;
      to_q <= 1'b0;
      cnt_q <= 1'b0;
      load_q <= 1'b0;
      dclr_q <= 1'b0;
      status_q <= 5'd0;
    end else begin
      cmd_q <= cmd_word;
      tog_q <= cmd_q[9];
      ptr_q <= ptr_d;
      sh_q <= sh_d;
      live_q <= live_d;
      state_q <= state_d;
      timer_q <= timer_d;
      clr_q <= clr_d;
      err_q <= err_d;
      to_q <= to_d;
      cnt_q <= cnt_d;
      load_q <= load_d;
      dclr_q <= dclr_d;
      status_q <= status_d;
    end
  end
endmodule

// File: tb/tb_dds_cfg_sequencer.sv
// tb_dds_cfg_sequencer: directed plus randomized check of dds_cfg_sequencer against a behavioural model
module tb_dds_cfg_sequencer;
  localparam int          ST  = 16;
  localparam logic [31:0] RST = 32'hCAFE_0001;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  cmd_word = 10'h2AA;
  logic        acc_wrap = 1'b0;
  logic [31:0] ftw;
  logic [15:0] phase_ofs;
  logic [1:0]  wave_sel;
  logic [7:0]  amplitude;
  logic        cfg_load, dds_clr;
  logic [4:0]  status;
  int total = 0, bad = 0;
  dds_cfg_sequencer #(.SYNC_TIMEOUT(ST), .RESET_FTW(RST)) dut (
    .clk(clk), .reset(reset), .cmd_word(cmd_word), .acc_wrap(acc_wrap),
    .ftw(ftw), .phase_ofs(phase_ofs), .wave_sel(wave_sel), .amplitude(amplitude),
    .cfg_load(cfg_load), .dds_clr(dds_clr), .status(status)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask
  logic [7:0]  m_sh [8];
  int          m_ptr, m_wcnt;
  logic [9:0]  m_cap;
  logic        m_tog, m_wait, m_pend, m_clrreq, m_err, m_to, m_cnt, m_load, m_dclr, m_valid = 1'b0;
  logic        m_cmd, m_busy, m_go, m_was_wait;
  logic [7:0]  m_p;
  logic [31:0] m_ftw;
  logic [15:0] m_ph;
  logic [1:0]  m_wv;
  logic [7:0]  m_amp;
  // reference: byte-array shadow, edge counter since entering the wait, one pending-apply flag
  always @(posedge clk) begin
    if (reset) begin
      {m_sh[3], m_sh[2], m_sh[1], m_sh[0]} = RST;
      m_sh[4] = 0; m_sh[5] = 0; m_sh[6] = 0; m_sh[7] = 8'hFF;
      m_ftw = RST; m_ph = 0; m_wv = 0; m_amp = 8'hFF;
      m_ptr = 0; m_wcnt = 0; m_wait = 0; m_pend = 0; m_clrreq = 0;
      m_err = 0; m_to = 0; m_cnt = 0; m_load = 0; m_dclr = 0;
      m_cap = cmd_word; m_tog = cmd_word[9]; m_valid = 1;
    end else begin
      m_cmd = m_cap[9] != m_tog;
      m_p = m_cap[7:0];
      m_busy = m_wait || m_pend;
      m_was_wait = m_wait;
      m_go = 0;
      m_load = 0; m_dclr = 0;
      if (m_pend) begin
        m_ftw = {m_sh[3], m_sh[2], m_sh[1], m_sh[0]};
        m_ph = {m_sh[5], m_sh[4]};
        m_wv = m_sh[6][1:0];
        m_amp = m_sh[7];
        m_load = 1; m_dclr = m_clrreq; m_cnt = !m_cnt; m_pend = 0;
      end
      if (m_cmd && m_cap[8]) begin
        if (m_p <= 8) m_ptr = int'(m_p);
        else if (m_p == 8'h0F) begin m_ptr = 0; m_err = 0; m_to = 0; end
        else m_err = 1;
      end else if (m_cmd) begin
        if (m_ptr < 8) begin
          m_sh[m_ptr] = (m_ptr == 6) ? {6'b0, m_p[1:0]} : m_p;
          m_ptr++;
        end else if (m_busy) m_err = 1;
        else begin
          m_clrreq = m_p[1];
          if (m_p[0]) m_go = 1;
          else begin m_wait = 1; m_wcnt = 0; end
        end
      end
      if (m_was_wait) begin
        m_wcnt++;
        if (acc_wrap) m_go = 1;
        else if (m_wcnt == ST) begin m_to = 1; m_go = 1; end
        if (m_go) m_wait = 0;
      end
      if (m_go) m_pend = 1;
      m_tog = m_cap[9];
      m_cap = cmd_word;
    end
  end
  // compare every output against the model on each falling edge
  always @(negedge clk) if (m_valid) begin
    chk("ftw", ftw, m_ftw);
    chk("phase_ofs", phase_ofs, m_ph);
    chk("wave_sel", wave_sel, m_wv);
    chk("amplitude", amplitude, m_amp);
    chk("cfg_load", cfg_load, m_load);
    chk("dds_clr", dds_clr, m_dclr);
    chk("status", status, {m_ptr == 8, m_cnt, m_to, m_err, m_wait || m_pend});
  end
  task automatic send(input logic a, input logic [7:0] p);
    cmd_word = {~cmd_word[9], a, p};
    @(negedge clk);
  endtask
  task automatic wait_load(output int k);
    k = 0;
    while (!cfg_load && k < 40) begin
      @(negedge clk);
      k++;
    end
  endtask
  int k;
  initial begin
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ftw", ftw, 32'hCAFE_0001);
    chk("rst_amp", amplitude, 8'hFF);
    chk("rst_status", status, 5'd0);
    chk("rst_load", cfg_load, 1'b0);
    send(1, 8'h00);
    send(0, 8'h78); send(0, 8'h56); send(0, 8'h34); send(0, 8'h12);
    send(0, 8'h00); send(0, 8'h40); send(0, 8'h02); send(0, 8'h80);
    send(1, 8'h08);
    send(0, 8'h01);
    wait_load(k);
    #1;
    chk("imm_latency", k, 2);
    chk("imm_ftw", ftw, 32'h1234_5678);
    chk("imm_phase", phase_ofs, 16'h4000);
    chk("imm_wave", wave_sel, 2'd2);
    chk("imm_amp", amplitude, 8'h80);
    chk("imm_dclr", dds_clr, 1'b0);
    @(negedge clk); #1;
    chk("imm_status", status, 5'b11000);
    chk("imm_load_once", cfg_load, 1'b0);
    send(0, 8'h02);
    repeat (10) @(negedge clk);
    #1;
    chk("sync_pending", status[0], 1'b1);
    chk("sync_wait_load", cfg_load, 1'b0);
    acc_wrap = 1;
    @(negedge clk);
    acc_wrap = 0;
    wait_load(k);
    #1;
    chk("sync_latency", k, 1);
    chk("sync_dclr", dds_clr, 1'b1);
    send(0, 8'h00);
    wait_load(k);
    #1;
    chk("timeout_latency", k, ST + 2);
    chk("timeout_flag", status[2], 1'b1);
    send(1, 8'h0F);
    @(negedge clk); #1;
    chk("timeout_clear", status[2], 1'b0);
    chk("ptr_zero", status[4], 1'b0);
    send(1, 8'h08);
    send(0, 8'h00);
    send(0, 8'h01);
    send(1, 8'h09);
    @(negedge clk); #1;
    chk("busy_err", status[1], 1'b1);
    chk("bad_addr_ptr", status[4], 1'b1);
    send(1, 8'h02);
    send(0, 8'hAB);
    acc_wrap = 1;
    @(negedge clk);
    acc_wrap = 0;
    wait_load(k);
    #1;
    chk("late_write_latency", k, 1);
    chk("late_write_ftw", ftw, 32'h12AB_5678);
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = $urandom_range(0, 9);
      acc_wrap = ($urandom_range(0, 24) == 0);
      reset = ($urandom_range(0, 399) == 0);
      if (reset) begin
        cmd_word = 10'($urandom);
        @(negedge clk);
      end else if (r < 2) begin
        int s;
        s = $urandom_range(0, 5);
        send(1, s < 3 ? 8'h08 : s == 3 ? 8'($urandom_range(0, 8)) : s == 4 ? 8'h0F : 8'($urandom));
      end else if (r < 5) send(0, 8'($urandom));
      else begin
        cmd_word = {cmd_word[9], 9'($urandom)};
        @(negedge clk);
      end
    end
    reset = 0;
    acc_wrap = 0;
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
